// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO family.
// Depth and occupancy-counter width are derived from the address width.
package fifo_pkg;

   function automatic int fifo_depth(input int asize);
      return 1 << asize;
   endfunction

   // An occupancy counter has to hold 0..depth, so it needs one extra bit.
   function automatic int level_width(input int asize);
      return asize + 1;
   endfunction

endpackage

// File: rtl/fifomem.sv
// Dual-port FIFO storage: synchronous write port, asynchronous read port.
// The contents are not reset.
module fifomem
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
) (
   input  logic             wclk,
   input  logic             wclken,
   input  logic             wfull,
   input  logic [ASIZE-1:0] waddr,
   input  logic [ASIZE-1:0] raddr,
   input  logic [DSIZE-1:0] wdata,
   output logic [DSIZE-1:0] rdata
);

   logic [DSIZE-1:0] mem [fifo_depth(ASIZE)];

   assign rdata = mem[raddr];

   always_ff @(posedge wclk) begin
      if (wclken && !wfull) mem[waddr] <= wdata;
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter, thresholds, flush, sticky errors,
// and either first-word-fall-through or registered read data.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4,
   parameter int FWFT  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   output logic             wfull,
   output logic             awfull,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             rvalid,
   output logic             rempty,
   output logic             arempty,
   input  logic [ASIZE:0]   awfull_thr,
   input  logic [ASIZE:0]   arempty_thr,
   output logic [ASIZE:0]   level,
   output logic             overflow,
   output logic             underflow
);

   localparam int DEPTH = fifo_depth(ASIZE);
   localparam int LW    = level_width(ASIZE);

   logic [ASIZE-1:0] waddr;
   logic [ASIZE-1:0] raddr;
   logic             wr_ok;
   logic             rd_ok;
   logic [DSIZE-1:0] mem_rdata;

   assign wfull   = (level == LW'(DEPTH));
   assign rempty  = (level == '0);
   assign awfull  = (level >= awfull_thr);
   assign arempty = (level <= arempty_thr);

   // Flush wins over both requests so nothing moves in the flush cycle.
   assign wr_ok = winc && !wfull  && !flush;
   assign rd_ok = rinc && !rempty && !flush;

   fifomem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_mem (
      .wclk   (clk),
      .wclken (wr_ok),
      .wfull  (wfull),
      .waddr  (waddr),
      .raddr  (raddr),
      .wdata  (wdata),
      .rdata  (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waddr     <= '0;
         raddr     <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         waddr     <= '0;
         raddr     <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok) waddr <= waddr + ASIZE'(1);
         if (rd_ok) raddr <= raddr + ASIZE'(1);
         case ({wr_ok, rd_ok})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (winc && wfull)  overflow  <= 1'b1;
         if (rinc && rempty) underflow <= 1'b1;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rdata  = mem_rdata;
         assign rvalid = !rempty;
      end else begin : g_reg_read
         // rdata deliberately holds across flush; only rvalid is cleared.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdata  <= '0;
               rvalid <= 1'b0;
            end else if (flush) begin
               rvalid <= 1'b0;
            end else begin
               rvalid <= rd_ok;
               if (rd_ok) rdata <= mem_rdata;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: one FWFT and one registered-read instance share the
// same stimulus and are compared against a queue-based reference model.
module tb_sync_fifo;

   localparam int DW = 8;
   localparam int AW = 2;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          winc = 1'b0;
   logic          rinc = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic [AW:0]   athr = 3'd3;
   logic [AW:0]   ethr = 3'd1;

   logic          f1_wfull, f1_awfull, f1_rvalid, f1_rempty, f1_arempty, f1_ovf, f1_unf;
   logic [DW-1:0] f1_rdata;
   logic [AW:0]   f1_level;
   logic          f0_wfull, f0_awfull, f0_rvalid, f0_rempty, f0_arempty, f0_ovf, f0_unf;
   logic [DW-1:0] f0_rdata;
   logic [AW:0]   f0_level;

   int total = 0;
   int bad = 0;

   logic [DW-1:0] q[$];
   bit            m_ovf, m_unf, m_rv0;
   logic [DW-1:0] m_rd0;

   always #5 clk = ~clk;

   sync_fifo #(.DSIZE(DW), .ASIZE(AW), .FWFT(1)) dut_fwft (
      .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
      .wfull(f1_wfull), .awfull(f1_awfull), .rinc(rinc), .rdata(f1_rdata),
      .rvalid(f1_rvalid), .rempty(f1_rempty), .arempty(f1_arempty),
      .awfull_thr(athr), .arempty_thr(ethr), .level(f1_level),
      .overflow(f1_ovf), .underflow(f1_unf)
   );

   sync_fifo #(.DSIZE(DW), .ASIZE(AW), .FWFT(0)) dut_reg (
      .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata),
      .wfull(f0_wfull), .awfull(f0_awfull), .rinc(rinc), .rdata(f0_rdata),
      .rvalid(f0_rvalid), .rempty(f0_rempty), .arempty(f0_arempty),
      .awfull_thr(athr), .arempty_thr(ethr), .level(f0_level),
      .overflow(f0_ovf), .underflow(f0_unf)
   );

   task automatic model_reset();
      q.delete();
      m_ovf = 0;
      m_unf = 0;
      m_rv0 = 0;
      m_rd0 = '0;
   endtask

   // Applies the inputs present at the clock edge to the reference model.
   task automatic model_step();
      bit full, empty;
      if (!rst_n) return;
      if (flush) begin
         q.delete();
         m_ovf = 0;
         m_unf = 0;
         m_rv0 = 0;
         return;
      end
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      if (winc && full)  m_ovf = 1;
      if (rinc && empty) m_unf = 1;
      m_rv0 = rinc && !empty;
      if (rinc && !empty) begin
         m_rd0 = q[0];
         void'(q.pop_front());
      end
      if (winc && !full) q.push_back(wdata);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0;
      winc = 0;
      rinc = 0;
   endtask

   task automatic do_flush();
      idle_inputs();
      flush = 1;
      tick();
      flush = 0;
   endtask

   task automatic test_reset();
      #2;
      total++; if (f1_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", f1_level); end
      total++; if (f1_rempty !== 1'b1 || f1_wfull !== 1'b0) begin bad++; $display("FAIL reset_empty_full got=%b%b exp=10", f1_rempty, f1_wfull); end
      total++; if (f1_arempty !== 1'b1 || f1_awfull !== (athr == 0)) begin bad++; $display("FAIL reset_thr got=%b%b exp=1%b", f1_arempty, f1_awfull, athr == 0); end
      total++; if (f1_ovf !== 1'b0 || f1_unf !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", f1_ovf, f1_unf); end
      total++; if (f0_rvalid !== 1'b0 || f0_rdata !== 8'h00) begin bad++; $display("FAIL reset_regread got=%b/%h exp=0/00", f0_rvalid, f0_rdata); end
      @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         winc = 1;
         wdata = 8'(8'h11 * (i + 1));
         tick();
         total++; if (f1_level !== 3'(i + 1)) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", f1_level, i + 1); end
         if (i == 0) begin
            total++; if (f1_rdata !== 8'h11 || f1_rempty !== 1'b0) begin bad++; $display("FAIL fill_fwft_head got=%h/%b exp=11/0", f1_rdata, f1_rempty); end
         end
         total++; if (f1_wfull !== (i == DEPTH - 1)) begin bad++; $display("FAIL fill_wfull got=%b exp=%b", f1_wfull, i == DEPTH - 1); end
      end
      winc = 0;
   endtask

   task automatic test_overflow_drain();
      winc = 1;
      wdata = 8'h55;
      tick();
      winc = 0;
      total++; if (f1_ovf !== 1'b1 || f1_level !== 3'd4) begin bad++; $display("FAIL ovf_set got=%b/%0d exp=1/4", f1_ovf, f1_level); end
      tick();
      total++; if (f1_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", f1_ovf); end
      for (int i = 0; i < DEPTH; i++) begin
         rinc = 1;
         total++; if (f1_rdata !== 8'(8'h11 * (i + 1))) begin bad++; $display("FAIL drain_fwft got=%h exp=%h", f1_rdata, 8'(8'h11 * (i + 1))); end
         tick();
         total++; if (f0_rdata !== 8'(8'h11 * (i + 1)) || f0_rvalid !== 1'b1) begin bad++; $display("FAIL drain_reg got=%h/%b exp=%h/1", f0_rdata, f0_rvalid, 8'(8'h11 * (i + 1))); end
      end
      rinc = 0;
      total++; if (f1_rempty !== 1'b1 || f0_rempty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b%b exp=11", f1_rempty, f0_rempty); end
   endtask

   task automatic test_underflow_simul();
      do_flush();
      rinc = 1;
      tick();
      rinc = 0;
      total++; if (f1_unf !== 1'b1 || f1_level !== 3'd0) begin bad++; $display("FAIL unf_set got=%b/%0d exp=1/0", f1_unf, f1_level); end
      for (int i = 0; i < DEPTH; i++) begin
         winc = 1;
         wdata = 8'($urandom_range(255));
         tick();
      end
      rinc = 1;
      wdata = 8'hEE;
      tick();
      total++; if (f1_level !== 3'd3 || f1_ovf !== 1'b1) begin bad++; $display("FAIL simul_full got=%0d/%b exp=3/1", f1_level, f1_ovf); end
      winc = 0;
      tick();
      // Level 2 now; simultaneous traffic must hold level and keep order across the wrap.
      for (int i = 0; i < 6; i++) begin
         winc = 1;
         rinc = 1;
         wdata = 8'(8'hC0 + i);
         total++; if (f1_rdata !== q[0]) begin bad++; $display("FAIL simul_order got=%h exp=%h", f1_rdata, q[0]); end
         tick();
         total++; if (f1_level !== 3'd2) begin bad++; $display("FAIL simul_level got=%0d exp=2", f1_level); end
      end
      idle_inputs();
   endtask

   task automatic test_thresholds();
      bit exp_e[5] = '{1, 1, 0, 0, 0};
      bit exp_f[5] = '{0, 0, 0, 1, 1};
      do_flush();
      athr = 3'd3;
      ethr = 3'd1;
      for (int l = 0; l <= DEPTH; l++) begin
         #1;
         total++; if (f1_arempty !== exp_e[l] || f1_awfull !== exp_f[l]) begin bad++; $display("FAIL thr_lvl%0d got=%b%b exp=%b%b", l, f1_arempty, f1_awfull, exp_e[l], exp_f[l]); end
         if (l < DEPTH) begin
            winc = 1;
            wdata = 8'($urandom_range(255));
            tick();
            winc = 0;
         end
      end
      ethr = 3'd4;
      #1;
      total++; if (f1_arempty !== 1'b1) begin bad++; $display("FAIL thr_ae_force got=%b exp=1", f1_arempty); end
      do_flush();
      athr = 3'd0;
      #1;
      total++; if (f1_awfull !== 1'b1 || f1_level !== 3'd0) begin bad++; $display("FAIL thr_af_force got=%b/%0d exp=1/0", f1_awfull, f1_level); end
      athr = 3'd3;
      ethr = 3'd1;
   endtask

   task automatic test_registered_read();
      do_flush();
      winc = 1;
      wdata = 8'hA5;
      tick();
      winc = 0;
      rinc = 1;
      tick();
      rinc = 0;
      total++; if (f0_rdata !== 8'hA5 || f0_rvalid !== 1'b1) begin bad++; $display("FAIL regread_pop got=%h/%b exp=a5/1", f0_rdata, f0_rvalid); end
      tick();
      total++; if (f0_rvalid !== 1'b0 || f0_rdata !== 8'hA5) begin bad++; $display("FAIL regread_after got=%h/%b exp=a5/0", f0_rdata, f0_rvalid); end
   endtask

   task automatic test_flush();
      do_flush();
      winc = 1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         wdata = 8'(8'h30 + i);
         tick();
      end
      winc = 0;
      rinc = 1;
      tick();
      rinc = 0;
      total++; if (f1_level !== 3'd3 || f1_ovf !== 1'b1) begin bad++; $display("FAIL flush_setup got=%0d/%b exp=3/1", f1_level, f1_ovf); end
      flush = 1;
      winc = 1;
      wdata = 8'h77;
      tick();
      idle_inputs();
      total++; if (f1_level !== 3'd0 || f1_rempty !== 1'b1 || f1_ovf !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0d/%b/%b exp=0/1/0", f1_level, f1_rempty, f1_ovf); end
      total++; if (f0_rvalid !== 1'b0 || f0_rdata !== 8'h30) begin bad++; $display("FAIL flush_regread got=%h/%b exp=30/0", f0_rdata, f0_rvalid); end
      tick();
      total++; if (f1_level !== 3'd0) begin bad++; $display("FAIL flush_nowrite got=%0d exp=0", f1_level); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if (c % 50 == 0) begin
            athr = 3'($urandom_range(DEPTH));
            ethr = 3'($urandom_range(DEPTH));
         end
         flush = ($urandom_range(39) == 0);
         winc  = ($urandom_range(99) < 55);
         rinc  = ($urandom_range(99) < 50);
         wdata = 8'($urandom_range(255));
         tick();
         total++; if (f1_level !== 3'(q.size()) || f0_level !== 3'(q.size())) begin bad++; $display("FAIL rnd_level c=%0d got=%0d/%0d exp=%0d", c, f1_level, f0_level, q.size()); end
         total++; if (f1_wfull !== (q.size() == DEPTH) || f1_rempty !== (q.size() == 0)) begin bad++; $display("FAIL rnd_flags c=%0d got=%b%b exp=%b%b", c, f1_wfull, f1_rempty, q.size() == DEPTH, q.size() == 0); end
         total++; if (f1_awfull !== (q.size() >= int'(athr)) || f1_arempty !== (q.size() <= int'(ethr))) begin bad++; $display("FAIL rnd_thr c=%0d got=%b%b exp=%b%b", c, f1_awfull, f1_arempty, q.size() >= int'(athr), q.size() <= int'(ethr)); end
         total++; if (f1_ovf !== m_ovf || f1_unf !== m_unf || f0_ovf !== m_ovf || f0_unf !== m_unf) begin bad++; $display("FAIL rnd_err c=%0d got=%b%b exp=%b%b", c, f1_ovf, f1_unf, m_ovf, m_unf); end
         total++; if (f1_rvalid !== (q.size() != 0) || f0_rvalid !== m_rv0) begin bad++; $display("FAIL rnd_rvalid c=%0d got=%b/%b exp=%b/%b", c, f1_rvalid, f0_rvalid, q.size() != 0, m_rv0); end
         if (q.size() != 0) begin
            total++; if (f1_rdata !== q[0]) begin bad++; $display("FAIL rnd_fwft c=%0d got=%h exp=%h", c, f1_rdata, q[0]); end
         end
         total++; if (f0_rdata !== m_rd0) begin bad++; $display("FAIL rnd_regread c=%0d got=%h exp=%h", c, f0_rdata, m_rd0); end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      do_flush();
      winc = 1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         wdata = 8'(8'h61 + i);
         tick();
      end
      winc = 0;
      rinc = 1;
      tick();
      rinc = 0;
      winc = 1;
      wdata = 8'h99;
      tick();
      #2;
      rst_n = 0;
      #1;
      model_reset();
      total++; if (f1_level !== 3'd0 || f1_rempty !== 1'b1 || f1_wfull !== 1'b0) begin bad++; $display("FAIL arst_level got=%0d/%b/%b exp=0/1/0", f1_level, f1_rempty, f1_wfull); end
      total++; if (f1_ovf !== 1'b0 || f1_arempty !== 1'b1 || f1_awfull !== 1'b0) begin bad++; $display("FAIL arst_flags got=%b/%b/%b exp=0/1/0", f1_ovf, f1_arempty, f1_awfull); end
      total++; if (f0_rvalid !== 1'b0 || f0_rdata !== 8'h00) begin bad++; $display("FAIL arst_regread got=%h/%b exp=00/0", f0_rdata, f0_rvalid); end
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      tick();
      total++; if (f1_level !== 3'd0 || f1_rempty !== 1'b1) begin bad++; $display("FAIL arst_release got=%0d/%b exp=0/1", f1_level, f1_rempty); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill();
      test_overflow_drain();
      test_underflow_simul();
      test_thresholds();
      test_registered_read();
      test_flush();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
